// File: rtl/soc_frame_loader_if.sv
// Word-stream handshake into the SOC frame loader: valid/ready transfer plus a frame resync.
interface soc_frame_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sync;

  modport master (output in_valid, output in_data, output in_sync, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_sync, output in_ready);
endinterface

// File: rtl/soc_frame_loader.sv
// Collects SOC1..SOC4,I float frames, validates them and publishes good frames to stable
// registered outputs, strobing once the downstream balancing datapath has had time to settle.
module soc_frame_loader #(
  parameter int SETTLE_CYCLES = 16,
  parameter int ERR_W         = 8,
  parameter int FRM_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  soc_frame_loader_if.slave  in_port,
  output logic [31:0]        soc1,
  output logic [31:0]        soc2,
  output logic [31:0]        soc3,
  output logic [31:0]        soc4,
  output logic [31:0]        I,
  output logic               out_stable,
  output logic               sample_strobe,
  output logic               err_pulse,
  output logic [ERR_W-1:0]   err_count,
  output logic [FRM_W-1:0]   frame_count
);

  typedef enum logic {COLLECT, SETTLE} state_t;

  localparam logic [7:0]  SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [31:0] ONE_F       = 32'h3F800000;

  state_t      state;
  logic [2:0]  idx;
  logic        frame_err;
  logic [7:0]  settle_cnt;
  logic [31:0] shadow [4];

  // SOC must be a strictly positive normal number.
  function automatic logic soc_bad(input logic [31:0] w);
    return w[31] | (w[30:23] == 8'h00) | (w[30:23] == 8'hFF);
  endfunction

  // Current may be signed zero or any finite normal; inf/NaN and denormals are rejected.
  function automatic logic cur_bad(input logic [31:0] w);
    return (w[30:23] == 8'hFF) | ((w[30:23] == 8'h00) & (w[22:0] != 23'd0));
  endfunction

  assign in_port.in_ready = (state == COLLECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      idx           <= 3'd0;
      frame_err     <= 1'b0;
      settle_cnt    <= 8'd0;
      soc1          <= ONE_F;
      soc2          <= ONE_F;
      soc3          <= ONE_F;
      soc4          <= ONE_F;
      I             <= 32'd0;
      out_stable    <= 1'b0;
      sample_strobe <= 1'b0;
      err_pulse     <= 1'b0;
      err_count     <= '0;
      frame_count   <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= 32'd0;
    end else begin
      err_pulse     <= 1'b0;
      sample_strobe <= 1'b0;
      case (state)
        COLLECT: begin
          // Sync takes priority: a word arriving alongside it is consumed and dropped.
          if (in_port.in_sync) begin
            idx       <= 3'd0;
            frame_err <= 1'b0;
          end else if (in_port.in_valid) begin
            if (idx == 3'd4) begin
              idx       <= 3'd0;
              frame_err <= 1'b0;
              if (frame_err | cur_bad(in_port.in_data)) begin
                err_pulse <= 1'b1;
                if (err_count != '1) err_count <= err_count + ERR_W'(1);
              end else begin
                soc1        <= shadow[0];
                soc2        <= shadow[1];
                soc3        <= shadow[2];
                soc4        <= shadow[3];
                I           <= in_port.in_data;
                out_stable  <= 1'b0;
                frame_count <= frame_count + FRM_W'(1);
                settle_cnt  <= SETTLE_INIT;
                state       <= SETTLE;
              end
            end else begin
              shadow[idx[1:0]] <= in_port.in_data;
              if (soc_bad(in_port.in_data)) frame_err <= 1'b1;
              idx <= idx + 3'd1;
            end
          end
        end
        SETTLE: begin
          // Strobe lands exactly SETTLE_CYCLES edges after the output update.
          if (settle_cnt == 8'd1) begin
            settle_cnt    <= 8'd0;
            out_stable    <= 1'b1;
            sample_strobe <= 1'b1;
            state         <= COLLECT;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_frame_loader.sv
// Directed self-checking bench for soc_frame_loader with hand-computed expectations.
module tb_soc_frame_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] soc1, soc2, soc3, soc4, I;
  logic        out_stable, sample_strobe, err_pulse;
  logic [7:0]  err_count;
  logic [15:0] frame_count;
  int          checks = 0;
  int          passes = 0;
  int          lat;
  int          ready_low;
  int          strobes;

  soc_frame_loader_if bus ();

  soc_frame_loader #(.SETTLE_CYCLES(16), .ERR_W(8), .FRM_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_port       (bus),
    .soc1          (soc1),
    .soc2          (soc2),
    .soc3          (soc3),
    .soc4          (soc4),
    .I             (I),
    .out_stable    (out_stable),
    .sample_strobe (sample_strobe),
    .err_pulse     (err_pulse),
    .err_count     (err_count),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Presents one word for exactly one posedge; returns 1ns after that edge.
  task automatic applyStimulus(input logic [31:0] word, input logic sync);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    bus.in_sync  = sync;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
  endtask

  task automatic sendFrame(input logic [31:0] w0, w1, w2, w3, w4);
    applyStimulus(w0, 1'b0);
    applyStimulus(w1, 1'b0);
    applyStimulus(w2, 1'b0);
    applyStimulus(w3, 1'b0);
    applyStimulus(w4, 1'b0);
  endtask

  // Called just after the update edge; bounded wait for the strobe.
  task automatic waitStrobe(output int latency, output int low_cycles);
    latency    = 999;
    low_cycles = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (!bus.in_ready) low_cycles++;
      if (sample_strobe) begin
        latency = k;
        break;
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    bus.in_sync  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_soc1", soc1, 32'h3F800000);
    checkOutput("rst_soc4", soc4, 32'h3F800000);
    checkOutput("rst_I", I, 32'h0);
    checkOutput("rst_stable", {31'd0, out_stable}, 32'd0);
    checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);
    checkOutput("rst_frame_count", {16'd0, frame_count}, 32'd0);
    checkOutput("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] valid frame");
    sendFrame(32'h3F000000, 32'h3F400000, 32'h3E800000, 32'h3F800000, 32'h40A00000);
    checkOutput("f1_soc1", soc1, 32'h3F000000);
    checkOutput("f1_soc2", soc2, 32'h3F400000);
    checkOutput("f1_soc3", soc3, 32'h3E800000);
    checkOutput("f1_soc4", soc4, 32'h3F800000);
    checkOutput("f1_I", I, 32'h40A00000);
    checkOutput("f1_stable_low", {31'd0, out_stable}, 32'd0);
    checkOutput("f1_frame_count", {16'd0, frame_count}, 32'd1);
    waitStrobe(lat, ready_low);
    checkOutput("f1_strobe_latency", lat, 32'd16);
    checkOutput("f1_ready_low_cycles", ready_low, 32'd16);
    checkOutput("f1_stable_at_strobe", {31'd0, out_stable}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("f1_strobe_single", {31'd0, sample_strobe}, 32'd0);

    $display("[TB] negative SOC3");
    sendFrame(32'h3F000000, 32'h3F400000, 32'hBF000000, 32'h3F800000, 32'h40A00000);
    checkOutput("f2_err_pulse", {31'd0, err_pulse}, 32'd1);
    checkOutput("f2_err_count", {24'd0, err_count}, 32'd1);
    checkOutput("f2_soc3_kept", soc3, 32'h3E800000);
    checkOutput("f2_stable_kept", {31'd0, out_stable}, 32'd1);
    checkOutput("f2_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("f2_err_pulse_single", {31'd0, err_pulse}, 32'd0);

    $display("[TB] NaN current then zero current");
    sendFrame(32'h3F000000, 32'h3F400000, 32'h3E800000, 32'h3F800000, 32'h7FC00000);
    checkOutput("f3_err_count", {24'd0, err_count}, 32'd2);
    checkOutput("f3_I_kept", I, 32'h40A00000);
    sendFrame(32'h3F100000, 32'h3F200000, 32'h3E800000, 32'h3F800000, 32'h00000000);
    checkOutput("f4_I_zero", I, 32'h0);
    checkOutput("f4_soc1", soc1, 32'h3F100000);
    checkOutput("f4_frame_count", {16'd0, frame_count}, 32'd2);
    waitStrobe(lat, ready_low);
    checkOutput("f4_strobe_latency", lat, 32'd16);

    $display("[TB] sync mid-frame");
    applyStimulus(32'h3F100000, 1'b0);
    applyStimulus(32'h3F200000, 1'b0);
    applyStimulus(32'h3F300000, 1'b1);
    sendFrame(32'h3E000000, 32'h3E400000, 32'h3E800000, 32'h3EC00000, 32'hC0400000);
    checkOutput("f5_soc1", soc1, 32'h3E000000);
    checkOutput("f5_soc2", soc2, 32'h3E400000);
    checkOutput("f5_soc4", soc4, 32'h3EC00000);
    checkOutput("f5_I_negative", I, 32'hC0400000);
    checkOutput("f5_frame_count", {16'd0, frame_count}, 32'd3);
    waitStrobe(lat, ready_low);
    checkOutput("f5_strobe_latency", lat, 32'd16);

    $display("[TB] error counter saturation");
    for (int n = 0; n < 256; n++)
      sendFrame(32'h00000000, 32'h3F400000, 32'h3E800000, 32'h3F800000, 32'h40A00000);
    checkOutput("f6_err_saturated", {24'd0, err_count}, 32'h000000FF);
    checkOutput("f6_I_kept", I, 32'hC0400000);
    sendFrame(32'h7F800000, 32'h3F400000, 32'h3E800000, 32'h3F800000, 32'h40A00000);
    checkOutput("f6_err_held", {24'd0, err_count}, 32'h000000FF);

    $display("[TB] reset during settle");
    sendFrame(32'h3F000000, 32'h3F400000, 32'h3E800000, 32'h3F800000, 32'h80000000);
    checkOutput("f7_I_neg_zero", I, 32'h80000000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("f7_rst_soc2", soc2, 32'h3F800000);
    checkOutput("f7_rst_I", I, 32'h0);
    checkOutput("f7_rst_stable", {31'd0, out_stable}, 32'd0);
    checkOutput("f7_rst_err_count", {24'd0, err_count}, 32'd0);
    checkOutput("f7_rst_frame_count", {16'd0, frame_count}, 32'd0);
    checkOutput("f7_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (sample_strobe) strobes++;
    end
    checkOutput("f7_no_strobe", strobes, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
